// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin arbiter that time-shares one ALU between two
// requesters. A job is accepted in IDLE, the ALU is loaded for one cycle,
// the scheduler waits ALU_LAT cycles for the result, then strobes it back
// to the owning requester in DONE. Illegal op 7 skips the ALU entirely.
module alu_scheduler #(
  parameter int WIDTH   = 8,
  parameter int ALU_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  output logic             alu_on,
  output logic [2:0]       alu_in_sel,
  output logic [WIDTH-1:0] alu_num1,
  output logic [WIDTH-1:0] alu_num2,
  output logic [6:0]       alu_out_sel,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam logic [3:0] CNT_INIT  = 4'(ALU_LAT - 1);
  localparam logic [2:0] OP_ILLEGAL = 3'd7;
  localparam logic [2:0] SEL_RESET   = 3'b000;
  localparam logic [2:0] SEL_LOAD    = 3'b010;
  localparam logic [2:0] SEL_PERSIST = 3'b100;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic             busy_q, busy_d;
  logic             resp0_valid_q, resp0_valid_d;
  logic             resp1_valid_q, resp1_valid_d;
  logic             resp_err_q, resp_err_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             alu_on_q, alu_on_d;
  logic [2:0]       alu_in_sel_q, alu_in_sel_d;
  logic [WIDTH-1:0] alu_num1_q, alu_num1_d;
  logic [WIDTH-1:0] alu_num2_q, alu_num2_d;
  logic [6:0]       alu_out_sel_q, alu_out_sel_d;

  logic             pick0, pick1, accept, win_owner;
  logic [2:0]       win_op;
  logic [WIDTH-1:0] win_a, win_b;

  // Arbitration: a lone requester wins; on contention the one not granted last wins.
  always_comb begin
    pick0      = req0_valid & (~req1_valid | last_grant_q);
    pick1      = req1_valid & (~req0_valid | ~last_grant_q);
    req0_ready = rst & (state_q == S_IDLE) & pick0;
    req1_ready = rst & (state_q == S_IDLE) & pick1;
    accept     = req0_ready | req1_ready;
    win_owner  = req1_ready;
    win_op     = req1_ready ? req1_op : req0_op;
    win_a      = req1_ready ? req1_a  : req0_a;
    win_b      = req1_ready ? req1_b  : req0_b;
  end

  // State register plus wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the counter reaching zero in WAIT marks the result edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (win_op == OP_ILLEGAL) ? S_DONE : S_LOAD;
      S_LOAD: begin
        state_d = S_WAIT;
        cnt_d   = CNT_INIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values for every registered output, keyed on the transition taken.
  always_comb begin
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    resp0_valid_d = 1'b0;
    resp1_valid_d = 1'b0;
    resp_err_d    = 1'b0;
    resp_data_d   = resp_data_q;
    alu_on_d      = alu_on_q;
    alu_in_sel_d  = alu_in_sel_q;
    alu_num1_d    = alu_num1_q;
    alu_num2_d    = alu_num2_q;
    alu_out_sel_d = alu_out_sel_q;
    busy_d        = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          owner_d = win_owner;
          if (win_op == OP_ILLEGAL) begin
            // Illegal op never touches the ALU; answer straight away with an error.
            resp0_valid_d = ~win_owner;
            resp1_valid_d = win_owner;
            resp_err_d    = 1'b1;
            resp_data_d   = '0;
          end else begin
            alu_on_d      = 1'b1;
            alu_in_sel_d  = SEL_LOAD;
            alu_num1_d    = win_a;
            alu_num2_d    = win_b;
            alu_out_sel_d = 7'b1000000 >> win_op;
          end
        end
      end
      S_LOAD: alu_in_sel_d = SEL_PERSIST;
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          resp_data_d   = alu_out;
          resp0_valid_d = ~owner_q;
          resp1_valid_d = owner_q;
          alu_on_d      = 1'b0;
          alu_in_sel_d  = SEL_RESET;
          alu_out_sel_d = '0;
        end
      end
      default: last_grant_d = owner_q;
    endcase
  end

  // Registered outputs and job bookkeeping; reset discards any in-flight job.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      busy_q        <= 1'b0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_data_q   <= '0;
      alu_on_q      <= 1'b0;
      alu_in_sel_q  <= SEL_RESET;
      alu_num1_q    <= '0;
      alu_num2_q    <= '0;
      alu_out_sel_q <= '0;
    end else begin
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      busy_q        <= busy_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp_err_q    <= resp_err_d;
      resp_data_q   <= resp_data_d;
      alu_on_q      <= alu_on_d;
      alu_in_sel_q  <= alu_in_sel_d;
      alu_num1_q    <= alu_num1_d;
      alu_num2_q    <= alu_num2_d;
      alu_out_sel_q <= alu_out_sel_d;
    end
  end

  assign state       = state_q;
  assign busy        = busy_q;
  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_data   = resp_data_q;
  assign alu_on      = alu_on_q;
  assign alu_in_sel  = alu_in_sel_q;
  assign alu_num1    = alu_num1_q;
  assign alu_num2    = alu_num2_q;
  assign alu_out_sel = alu_out_sel_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Testbench for alu_scheduler: three instances (ALU_LAT 2, 1, 4) share the
// request inputs, each with its own latency-accurate ALU model.
module tb_alu_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;

  logic       r0_rdy [3];
  logic       r1_rdy [3];
  logic       v0 [3];
  logic       v1 [3];
  logic       err [3];
  logic       on [3];
  logic       busy_o [3];
  logic [7:0] rdata [3];
  logic [7:0] n1 [3];
  logic [7:0] n2 [3];
  logic [7:0] aout [3];
  logic [2:0] isel [3];
  logic [6:0] osel [3];
  logic [1:0] st [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [6:0] sel);
    case (sel)
      7'b1000000: return a + b;
      7'b0100000: return a - b;
      7'b0010000: return a & b;
      7'b0001000: return a | b;
      7'b0000100: return a ^ b;
      7'b0000010: return ~a;
      7'b0000001: return {a[3:0], b[3:0]};
      default:    return 8'hEE;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    int         ld_cnt;
    logic [7:0] res;

    alu_scheduler #(.WIDTH(8), .ALU_LAT(L)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(r0_rdy[g]), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(r1_rdy[g]), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .resp0_valid(v0[g]), .resp1_valid(v1[g]), .resp_data(rdata[g]), .resp_err(err[g]),
      .alu_on(on[g]), .alu_in_sel(isel[g]), .alu_num1(n1[g]), .alu_num2(n2[g]),
      .alu_out_sel(osel[g]), .alu_out(aout[g]), .busy(busy_o[g]), .state(st[g])
    );

    // ALU model: result appears ALU_LAT cycles after the load cycle, garbage before.
    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        ld_cnt <= 0;
        res    <= 8'h00;
      end else if (isel[g] == 3'b010) begin
        ld_cnt <= 1;
        res    <= alu_model(n1[g], n2[g], osel[g]);
      end else if (ld_cnt != 0 && ld_cnt < 100) begin
        ld_cnt <= ld_cnt + 1;
      end
    end
    assign aout[g] = (ld_cnt >= L) ? res : 8'hA5;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 3'd0; req1_op = 3'd0;
    req0_a = 8'h00; req0_b = 8'h00; req1_a = 8'h00; req1_b = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_op = 3'd0; req1_op = 3'd0;
    req0_a = 8'h11; req0_b = 8'h22; req1_a = 8'h00; req1_b = 8'h00;
    repeat (2) @(posedge clk);
    #2;
    tests++;
    if (st[0] !== 2'b00 || busy_o[0] !== 1'b0) begin
      fails++; $display("FAIL reset_state: state=%b busy=%b want 00/0", st[0], busy_o[0]);
    end
    tests++;
    if (r0_rdy[0] !== 1'b0 || r1_rdy[0] !== 1'b0) begin
      fails++; $display("FAIL reset_ready: got %b%b want 00", r0_rdy[0], r1_rdy[0]);
    end
    tests++;
    if (v0[0] !== 1'b0 || v1[0] !== 1'b0 || err[0] !== 1'b0 || rdata[0] !== 8'h00) begin
      fails++; $display("FAIL reset_resp: v0=%b v1=%b err=%b data=%h want 0", v0[0], v1[0], err[0], rdata[0]);
    end
    tests++;
    if (on[0] !== 1'b0 || isel[0] !== 3'b000 || osel[0] !== 7'b0 || n1[0] !== 8'h00 || n2[0] !== 8'h00) begin
      fails++; $display("FAIL reset_alu: on=%b in_sel=%b out_sel=%b n1=%h n2=%h want 0", on[0], isel[0], osel[0], n1[0], n2[0]);
    end
    req0_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_single;
    apply_reset();
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'h57; req0_b = 8'h1A;
    #1;
    tests++;
    if (r0_rdy[0] !== 1'b1 || r1_rdy[0] !== 1'b0) begin
      fails++; $display("FAIL single_ready: got %b%b want 10", r0_rdy[0], r1_rdy[0]);
    end
    tick();  // cycle 1
    req0_valid = 1'b0;
    tests++;
    if (osel[0] !== 7'b1000000 || isel[0] !== 3'b010 || on[0] !== 1'b1) begin
      fails++; $display("FAIL single_load: out_sel=%b in_sel=%b on=%b want 1000000/010/1", osel[0], isel[0], on[0]);
    end
    tests++;
    if (n1[0] !== 8'h57 || n2[0] !== 8'h1A || st[0] !== 2'b01) begin
      fails++; $display("FAIL single_operands: n1=%h n2=%h state=%b want 57/1a/01", n1[0], n2[0], st[0]);
    end
    tick();  // cycle 2
    tests++;
    if (isel[0] !== 3'b100 || on[0] !== 1'b1 || osel[0] !== 7'b1000000) begin
      fails++; $display("FAIL single_wait2: in_sel=%b on=%b out_sel=%b want 100/1/1000000", isel[0], on[0], osel[0]);
    end
    tick();  // cycle 3
    tests++;
    if (isel[0] !== 3'b100 || v0[0] !== 1'b0 || st[0] !== 2'b10) begin
      fails++; $display("FAIL single_wait3: in_sel=%b v0=%b state=%b want 100/0/10", isel[0], v0[0], st[0]);
    end
    tick();  // cycle 4
    tests++;
    if (v0[0] !== 1'b1 || v1[0] !== 1'b0 || rdata[0] !== 8'h71 || err[0] !== 1'b0) begin
      fails++; $display("FAIL single_resp: v0=%b v1=%b data=%h err=%b want 1/0/71/0", v0[0], v1[0], rdata[0], err[0]);
    end
    tests++;
    if (on[0] !== 1'b0 || isel[0] !== 3'b000 || osel[0] !== 7'b0 || st[0] !== 2'b11) begin
      fails++; $display("FAIL single_done_alu: on=%b in_sel=%b out_sel=%b state=%b want 0/000/0/11", on[0], isel[0], osel[0], st[0]);
    end
    tick();  // cycle 5
    tests++;
    if (v0[0] !== 1'b0 || st[0] !== 2'b00 || busy_o[0] !== 1'b0 || rdata[0] !== 8'h71) begin
      fails++; $display("FAIL single_idle: v0=%b state=%b busy=%b data=%h want 0/00/0/71", v0[0], st[0], busy_o[0], rdata[0]);
    end
  endtask

  task automatic test_simultaneous;
    apply_reset();
    req0_valid = 1'b1; req0_op = 3'd1; req0_a = 8'h02; req0_b = 8'h04;
    req1_valid = 1'b1; req1_op = 3'd6; req1_a = 8'h07; req1_b = 8'h02;
    #1;
    tests++;
    if (r0_rdy[0] !== 1'b1 || r1_rdy[0] !== 1'b0) begin
      fails++; $display("FAIL sim_first_grant: got %b%b want 10", r0_rdy[0], r1_rdy[0]);
    end
    tick();  // cycle 1
    req0_valid = 1'b0;
    tests++;
    if (osel[0] !== 7'b0100000) begin
      fails++; $display("FAIL sim_sel0: got %b want 0100000", osel[0]);
    end
    repeat (3) tick();  // cycle 4
    tests++;
    if (v0[0] !== 1'b1 || v1[0] !== 1'b0 || rdata[0] !== 8'hFE) begin
      fails++; $display("FAIL sim_resp0: v0=%b v1=%b data=%h want 1/0/fe", v0[0], v1[0], rdata[0]);
    end
    tick();  // cycle 5
    #1;
    tests++;
    if (r1_rdy[0] !== 1'b1 || r0_rdy[0] !== 1'b0) begin
      fails++; $display("FAIL sim_second_grant: got %b%b want 01", r0_rdy[0], r1_rdy[0]);
    end
    tick();  // cycle 6
    req1_valid = 1'b0;
    tests++;
    if (osel[0] !== 7'b0000001) begin
      fails++; $display("FAIL sim_sel1: got %b want 0000001", osel[0]);
    end
    repeat (3) tick();  // cycle 9
    tests++;
    if (v1[0] !== 1'b1 || v0[0] !== 1'b0 || rdata[0] !== 8'h72) begin
      fails++; $display("FAIL sim_resp1: v0=%b v1=%b data=%h want 0/1/72", v0[0], v1[0], rdata[0]);
    end
    tick();
  endtask

  task automatic test_contention;
    int  order [6];
    int  ng;
    bit  viol;
    bit  seen;
    apply_reset();
    ng = 0; viol = 1'b0; seen = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 8'h01; req0_b = 8'h02;
    req1_valid = 1'b1; req1_op = 3'd6; req1_a = 8'h07; req1_b = 8'h02;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      #1;
      if (busy_o[0] && (r0_rdy[0] || r1_rdy[0])) viol = 1'b1;
      if (r0_rdy[0]) begin
        order[ng] = 0; ng++;
      end else if (r1_rdy[0]) begin
        order[ng] = 1; ng++;
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tests++;
    if (ng !== 6) begin
      fails++; $display("FAIL cont_grant_count: got %0d want 6", ng);
    end
    for (int i = 0; i < ng; i++) begin
      tests++;
      if (order[i] !== (i % 2)) begin
        fails++; $display("FAIL cont_order[%0d]: got %0d want %0d", i, order[i], i % 2);
      end
    end
    tests++;
    if (viol !== 1'b0) begin
      fails++; $display("FAIL cont_ready_while_busy: got %b want 0", viol);
    end
    for (int c = 0; c < 20 && !seen; c++) begin
      if (v1[0]) seen = 1'b1;
      else tick();
    end
    tests++;
    if (seen !== 1'b1 || rdata[0] !== 8'h72) begin
      fails++; $display("FAIL cont_last_resp: seen=%b data=%h want 1/72", seen, rdata[0]);
    end
    tick();
  endtask

  task automatic test_illegal;
    bit on_seen;
    on_seen = 1'b0;
    req1_valid = 1'b1; req1_op = 3'd7; req1_a = 8'h33; req1_b = 8'h44;
    #1;
    if (on[0]) on_seen = 1'b1;
    tests++;
    if (r1_rdy[0] !== 1'b1) begin
      fails++; $display("FAIL illegal_ready: got %b want 1", r1_rdy[0]);
    end
    tick();  // cycle 1
    req1_valid = 1'b0;
    if (on[0]) on_seen = 1'b1;
    tests++;
    if (v1[0] !== 1'b1 || v0[0] !== 1'b0 || err[0] !== 1'b1 || rdata[0] !== 8'h00) begin
      fails++; $display("FAIL illegal_resp: v1=%b v0=%b err=%b data=%h want 1/0/1/00", v1[0], v0[0], err[0], rdata[0]);
    end
    tests++;
    if (st[0] !== 2'b11 || isel[0] !== 3'b000) begin
      fails++; $display("FAIL illegal_state: state=%b in_sel=%b want 11/000", st[0], isel[0]);
    end
    tick();  // cycle 2
    if (on[0]) on_seen = 1'b1;
    tests++;
    if (v1[0] !== 1'b0 || st[0] !== 2'b00 || on_seen !== 1'b0) begin
      fails++; $display("FAIL illegal_after: v1=%b state=%b alu_on_seen=%b want 0/00/0", v1[0], st[0], on_seen);
    end
  endtask

  task automatic test_reset_mid_op;
    bit resp_seen;
    resp_seen = 1'b0;
    apply_reset();
    // A completed req0 job makes req1 the favoured requester.
    req0_valid = 1'b1; req0_op = 3'd3; req0_a = 8'hF0; req0_b = 8'h0F;
    tick();
    req0_valid = 1'b0;
    for (int c = 0; c < 20 && st[0] != 2'b00; c++) tick();
    tests++;
    if (st[0] !== 2'b00 || rdata[0] !== 8'hFF) begin
      fails++; $display("FAIL midrst_prejob: state=%b data=%h want 00/ff", st[0], rdata[0]);
    end
    req1_valid = 1'b1; req1_op = 3'd0; req1_a = 8'h01; req1_b = 8'h01;
    tick();  // cycle 1
    req1_valid = 1'b0;
    tick();  // cycle 2
    tests++;
    if (st[0] !== 2'b10) begin
      fails++; $display("FAIL midrst_in_wait: got %b want 10", st[0]);
    end
    #2;
    rst = 1'b0;
    #1;
    tests++;
    if (st[0] !== 2'b00 || busy_o[0] !== 1'b0 || on[0] !== 1'b0 || isel[0] !== 3'b000) begin
      fails++; $display("FAIL midrst_state: state=%b busy=%b on=%b in_sel=%b want 00/0/0/000", st[0], busy_o[0], on[0], isel[0]);
    end
    tests++;
    if (osel[0] !== 7'b0 || n1[0] !== 8'h00 || n2[0] !== 8'h00) begin
      fails++; $display("FAIL midrst_alu: out_sel=%b n1=%h n2=%h want 0", osel[0], n1[0], n2[0]);
    end
    for (int c = 0; c < 3; c++) begin
      if (v0[0] || v1[0]) resp_seen = 1'b1;
      tick();
    end
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (v0[0] || v1[0]) resp_seen = 1'b1;
      tick();
    end
    tests++;
    if (resp_seen !== 1'b0) begin
      fails++; $display("FAIL midrst_no_resp: got %b want 0", resp_seen);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    tests++;
    if (r0_rdy[0] !== 1'b1 || r1_rdy[0] !== 1'b0) begin
      fails++; $display("FAIL midrst_next_grant: got %b%b want 10", r0_rdy[0], r1_rdy[0]);
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_latency_sweep;
    int         cyc [3];
    logic [7:0] dat [3];
    int         exp_cyc [3];
    exp_cyc[0] = 4; exp_cyc[1] = 3; exp_cyc[2] = 6;
    for (int g = 0; g < 3; g++) begin
      cyc[g] = -1; dat[g] = 8'h00;
    end
    apply_reset();
    req0_valid = 1'b1; req0_op = 3'd4; req0_a = 8'h3C; req0_b = 8'h0F;
    tick();  // cycle 1
    req0_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      for (int g = 0; g < 3; g++) begin
        if (v0[g] && cyc[g] < 0) begin
          cyc[g] = c; dat[g] = rdata[g];
        end
      end
      tick();
    end
    for (int g = 0; g < 3; g++) begin
      tests++;
      if (cyc[g] !== exp_cyc[g] || dat[g] !== 8'h33) begin
        fails++; $display("FAIL sweep_inst%0d: cycle=%0d data=%h want %0d/33", g, cyc[g], dat[g], exp_cyc[g]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_contention();
    test_illegal();
    test_reset_mid_op();
    test_latency_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Round-robin scheduler that shares the single 8-bit ALU datapath between two requesters. It accepts one operation at a time over a valid/ready handshake and drives the ALU's `on`, `in_sel` and one-hot `out_sel` controls through a load/wait sequence. It then captures the ALU result and returns it to the owning requester with a one-cycle response strobe. It sits between the requesting blocks and the ALU top, replacing direct testbench driving of `in_sel` and `out_sel`.

## Interface
- `WIDTH`, default 8: operand and result width.
- `ALU_LAT`, default 2, legal range 1..15: cycles from the ALU load cycle until `alu_out` is valid.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req0_valid` in 1: requester 0 presents an operation.
- `req0_ready` out 1: requester 0's operation is accepted this cycle.
- `req0_op` in 3: operation index 0..6; 7 is illegal.
- `req0_a`, `req0_b` in WIDTH: operands.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`: same as requester 0, for requester 1.
- `resp0_valid`, `resp1_valid` out 1: one-cycle result strobe to the owning requester.
- `resp_data` out WIDTH: result, held until the next DONE.
- `resp_err` out 1: the response is for an illegal op; qualified by `respN_valid`.
- `alu_on` out 1: ALU enable.
- `alu_in_sel` out 3: ALU input control, bits {persist, load, reset}.
- `alu_num1`, `alu_num2` out WIDTH: ALU operands.
- `alu_out_sel` out 7: one-hot operation select.
- `alu_out` in WIDTH: ALU result.
- `busy` out 1: scheduler is not in IDLE.
- `state` out 2: current FSM state, for debug.

## Operation
- **State encoding:** IDLE=00, LOAD=01, WAIT=10, DONE=11.
- **Reset values (all outputs):**
  - `state`=IDLE, `busy`=0, `req*_ready`=0, `resp*_valid`=0, `resp_err`=0, `resp_data`=0.
  - `alu_on`=0, `alu_in_sel`=000, `alu_num1`/`alu_num2`=0, `alu_out_sel`=0000000.
  - `last_grant`=1, so requester 0 wins the first contention.
- **IDLE:**
  - Winner selection: if exactly one `reqN_valid` is high, that requester wins. If both are high, the requester not equal to `last_grant` wins.
  - `reqN_ready` is combinational, high only for the winner and only in IDLE. The transfer occurs on valid&ready.
  - On transfer, register the owner, op, a and b.
  - Next state is LOAD, or DONE if op==7.
  - The ALU is driven with `alu_on`=0 and `alu_in_sel`=000.
- **LOAD (1 cycle):**
  - Drive `alu_on`=1, `alu_in_sel`=010, `alu_num1`=a, `alu_num2`=b.
  - Drive `alu_out_sel` = 7'b1000000 >> op (op 0 gives 1000000, op 6 gives 0000001).
  - Load the wait counter with ALU_LAT-1. Next state is WAIT.
- **WAIT (ALU_LAT cycles):**
  - Drive `alu_in_sel`=100 (persist). `alu_on`, operands and `alu_out_sel` are held.
  - While the counter is nonzero, it decrements.
  - When the counter is zero, `resp_data` <= `alu_out` on that edge and the next state is DONE.
- **DONE (1 cycle):**
  - `resp<owner>_valid`=1. `resp_err`=1 only for op 7; in that case `resp_data` is 0 and the ALU was never enabled.
  - `last_grant` <= owner. Next state is IDLE.
  - `alu_on`=0, `alu_in_sel`=000, `alu_out_sel`=0.
- **Requests during a job:** requests arriving while `busy` get no ready. They must hold valid and their fields stable until accepted.
- **Changing requests:** a requester may drop valid or change its fields before acceptance; only the values present on the accept edge are used.
- **Mid-operation reset:** asserting `rst` in any state forces all reset values immediately, asynchronously. The in-flight job is discarded with no response, and `last_grant` returns to 1.

## Timing
- **Request-to-response latency:** accept at edge 0, LOAD in cycle 1, WAIT in cycles 2..1+ALU_LAT, `respN_valid` in cycle 2+ALU_LAT.
  - With ALU_LAT=2 the response is in cycle 4.
  - An illegal op responds in cycle 1.
- **Throughput:** back-to-back accepts are 3+ALU_LAT cycles apart (5 cycles with ALU_LAT=2), because the IDLE cycle that follows DONE is the earliest possible grant.
- **Fairness:** with both requesters continuously valid, grants strictly alternate 0,1,0,1…
- **ALU controls:** all `alu_*` outputs and `resp_data` are registered. `req*_ready` is the only combinational output.

## Test plan
- **Single request, op 0:** after reset release, req0 sends op=0, a=0x57, b=0x1A. The ALU model returns a+b after ALU_LAT=2.
  - Required: `alu_out_sel`=1000000 and `alu_in_sel`=010 in cycle 1; `alu_in_sel`=100 in cycles 2-3.
  - Required: `resp0_valid` in cycle 4 with `resp_data`=0x71 and `resp_err`=0.
- **Simultaneous requests:** req0 (op 1, a=0x02, b=0x04) and req1 (op 6, a=0x07, b=0x02) are both valid from reset.
  - Required: req0 is granted first with `alu_out_sel`=0100000; req1 is granted 5 cycles later with `alu_out_sel`=0000001.
  - Required: the responses arrive on `resp0_valid` then `resp1_valid`.
- **Continuous contention:** both requesters are valid for 6 jobs. Required: grant order 0,1,0,1,0,1, with no `ready` asserted while `busy`=1.
- **Illegal op:** req1 sends op=7. Required: `resp1_valid` with `resp_err`=1 and `resp_data`=0 in cycle 1, and `alu_on` never asserted.
- **Reset mid-operation:** assert `rst`=0 during WAIT. Required: `state`=00 and all `alu_*`=0 immediately, no `resp*_valid`, and req0 wins the next contention.
- **Latency sweep:** run with ALU_LAT=1 and with ALU_LAT=4. Required: responses in cycles 3 and 6 respectively, each capturing the model result present on the last WAIT edge.
